// File: rtl/fbmem_responder_pkg.sv
// Shared definitions for the frame-buffer memory responder: bus command
// encoding, controller state encoding and burst length decoding.
package fbmem_responder_pkg;

    typedef enum logic [2:0] {
        CMD_IDLE   = 3'b000,
        CMD_WDATA  = 3'b001,
        CMD_RDREQ  = 3'b010,
        CMD_RDATA  = 3'b011,
        CMD_WRREQ  = 3'b100,
        CMD_WRRESP = 3'b101
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_RESP = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_RD_BID  = 3'd3,
        ST_RD_DATA = 3'd4
    } state_e;

    // Burst length code to beat count: 00=1, 01=2, 10=4, 11=8.
    function automatic logic [3:0] len_to_beats(input logic [1:0] len);
        logic [3:0] beats;
        case (len)
            2'b00:   beats = 4'd1;
            2'b01:   beats = 4'd2;
            2'b10:   beats = 4'd4;
            default: beats = 4'd8;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/fbmem_array.sv
// Pixel word storage: one synchronous write port, one combinational read
// port. Contents are deliberately left untouched by reset.
module fbmem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    // Commit one word per cycle when the controller accepts a data beat.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fbmem_responder.sv
// Bus target emulating the video frame-buffer memory. Accepts write bursts to
// preload pixels and answers read bursts after winning arbitration. Every bus
// output is registered; the next-state logic computes the value each output
// should carry during the cycle after the current edge.
module fbmem_responder
    import fbmem_responder_pkg::*;
#(
    parameter int         DEPTH     = 1024,
    parameter int         AW        = $clog2(DEPTH),
    parameter logic [3:0] TARGET_ID = 4'h1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        selin,
    input  logic [2:0]  cmdin,
    input  logic [1:0]  lenin,
    input  logic [31:0] addrdatain,
    input  logic        ackin,
    output logic [1:0]  reqout,
    output logic [1:0]  lenout,
    output logic [31:0] addrdataout,
    output logic [2:0]  cmdout,
    output logic [3:0]  reqtar
);

    state_e      state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]  count_q, count_d;     // beats still to transfer
    logic [1:0]  len_q, len_d;
    logic [1:0]  reqout_q, reqout_d;
    logic [1:0]  lenout_q, lenout_d;
    logic [31:0] data_q, data_d;
    logic [2:0]  cmdout_q, cmdout_d;
    logic [3:0]  reqtar_q, reqtar_d;

    logic        mem_we;
    logic [31:0] mem_rdata;

    // Only the word-address bits of the byte address are meaningful.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addrdatain[31:AW+2], addrdatain[1:0]};

    fbmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (addr_q),
        .wdata_i (addrdatain),
        .raddr_i (addr_q),
        .rdata_o (mem_rdata)
    );

    // State, burst bookkeeping and registered bus outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            count_q  <= '0;
            len_q    <= '0;
            reqout_q <= '0;
            lenout_q <= '0;
            data_q   <= '0;
            cmdout_q <= '0;
            reqtar_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            len_q    <= len_d;
            reqout_q <= reqout_d;
            lenout_q <= lenout_d;
            data_q   <= data_d;
            cmdout_q <= cmdout_d;
            reqtar_q <= reqtar_d;
        end
    end

    // Next-state decode; outputs default to idle bus values every cycle.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        count_d  = count_q;
        len_d    = len_q;
        reqout_d = 2'b00;
        lenout_d = 2'b00;
        data_d   = '0;
        cmdout_d = CMD_IDLE;
        reqtar_d = 4'h0;
        mem_we   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (selin && cmdin == CMD_WRREQ) begin
                    addr_d   = addrdatain[AW+1:2];
                    count_d  = len_to_beats(lenin);
                    len_d    = lenin;
                    cmdout_d = CMD_WRRESP;
                    state_d  = ST_WR_RESP;
                end else if (selin && cmdin == CMD_RDREQ) begin
                    addr_d   = addrdatain[AW+1:2];
                    count_d  = len_to_beats(lenin);
                    len_d    = lenin;
                    reqout_d = 2'b11;
                    reqtar_d = TARGET_ID;
                    state_d  = ST_RD_BID;
                end
            end

            // The write response is on the bus during this single cycle.
            ST_WR_RESP: begin
                state_d = ST_WR_DATA;
            end

            ST_WR_DATA: begin
                if (selin && cmdin == CMD_WDATA) begin
                    mem_we  = 1'b1;
                    addr_d  = addr_q + 1'b1;
                    count_d = count_q - 1'b1;
                    if (count_q == 4'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            // Keep bidding until granted; the grant edge launches beat 0.
            ST_RD_BID: begin
                if (ackin) begin
                    cmdout_d = CMD_RDATA;
                    data_d   = mem_rdata;
                    lenout_d = len_q;
                    addr_d   = addr_q + 1'b1;
                    count_d  = count_q - 1'b1;
                    state_d  = ST_RD_DATA;
                end else begin
                    reqout_d = 2'b11;
                    reqtar_d = TARGET_ID;
                end
            end

            // A beat is on the bus in this state; launch the next or finish.
            ST_RD_DATA: begin
                if (count_q != 4'd0) begin
                    cmdout_d = CMD_RDATA;
                    data_d   = mem_rdata;
                    lenout_d = len_q;
                    addr_d   = addr_q + 1'b1;
                    count_d  = count_q - 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign reqout      = reqout_q;
    assign lenout      = lenout_q;
    assign addrdataout = data_q;
    assign cmdout      = cmdout_q;
    assign reqtar      = reqtar_q;

endmodule

// File: tb/tb_fbmem_responder.sv
// Directed plus randomized bench for fbmem_responder with a small depth so
// address wrap is exercised. A plain word array models the frame buffer.
module tb_fbmem_responder;

    localparam int         DEPTH = 16;
    localparam int         AW    = 4;
    localparam logic [3:0] TID   = 4'h1;

    logic        clk = 1'b0;
    logic        reset;
    logic        selin;
    logic [2:0]  cmdin;
    logic [1:0]  lenin;
    logic [31:0] addrdatain;
    logic        ackin;
    logic [1:0]  reqout;
    logic [1:0]  lenout;
    logic [31:0] addrdataout;
    logic [2:0]  cmdout;
    logic [3:0]  reqtar;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] mdl [DEPTH];

    fbmem_responder #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .TARGET_ID (TID)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .selin       (selin),
        .cmdin       (cmdin),
        .lenin       (lenin),
        .addrdatain  (addrdatain),
        .ackin       (ackin),
        .reqout      (reqout),
        .lenout      (lenout),
        .addrdataout (addrdataout),
        .cmdout      (cmdout),
        .reqtar      (reqtar)
    );

    always #5 clk = ~clk;

    // Advance one cycle; drive and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bus_idle(input string tag);
        check({tag, ".reqout"}, 32'(reqout), 32'd0);
        check({tag, ".lenout"}, 32'(lenout), 32'd0);
        check({tag, ".data"},   addrdataout, 32'd0);
        check({tag, ".cmdout"}, 32'(cmdout), 32'd0);
        check({tag, ".reqtar"}, 32'(reqtar), 32'd0);
    endtask

    function automatic int word_of(input logic [31:0] byte_addr, input int i);
        return (int'(byte_addr >> 2) + i) % DEPTH;
    endfunction

    // Write burst; data is base+i or random. Optional idle cycles between beats.
    task automatic do_write(input logic [31:0] addr, input logic [1:0] len,
                            input bit rnd, input logic [31:0] base, input bit stalls);
        int beats;
        logic [31:0] d;
        beats = 1 << len;
        $display("WRITE addr=%h len=%0d beats=%0d stalls=%0d", addr, len, beats, stalls);
        selin = 1'b1; cmdin = 3'b100; lenin = len; addrdatain = addr;
        tick();
        check("wr_resp", 32'(cmdout), 32'd5);
        cmdin = 3'b000; addrdatain = 32'hDEAD_0000;
        tick();
        check("wr_resp_one_cycle", 32'(cmdout), 32'd0);
        for (int i = 0; i < beats; i++) begin
            if (stalls && ($urandom_range(0, 1) == 1)) begin
                cmdin = 3'b000; addrdatain = $urandom;
                tick();
            end
            d = rnd ? $urandom : base + 32'(i);
            cmdin = 3'b001; addrdatain = d;
            tick();
            mdl[word_of(addr, i)] = d;
        end
        cmdin = 3'b000; addrdatain = '0;
        check("wr_done_cmd", 32'(cmdout), 32'd0);
    endtask

    // Read burst with a grant delay; optionally fire a stray read request
    // during the data phase, which must be ignored.
    task automatic do_read(input logic [31:0] addr, input logic [1:0] len,
                           input int delay, input bit inject);
        int beats;
        beats = 1 << len;
        $display("READ  addr=%h len=%0d beats=%0d delay=%0d inject=%0d", addr, len, beats, delay, inject);
        selin = 1'b1; cmdin = 3'b010; lenin = len; addrdatain = addr; ackin = 1'b0;
        tick();
        cmdin = 3'b000; addrdatain = '0;
        for (int k = 0; k < delay; k++) begin
            check("bid_reqout", 32'(reqout), 32'd3);
            check("bid_reqtar", 32'(reqtar), 32'(TID));
            check("bid_cmdout", 32'(cmdout), 32'd0);
            tick();
        end
        check("grant_reqout", 32'(reqout), 32'd3);
        check("grant_reqtar", 32'(reqtar), 32'(TID));
        ackin = 1'b1;
        tick();
        ackin = 1'b0;
        for (int b = 0; b < beats; b++) begin
            check("beat_cmd",    32'(cmdout), 32'd3);
            check("beat_data",   addrdataout, mdl[word_of(addr, b)]);
            check("beat_lenout", 32'(lenout), 32'(len));
            check("beat_reqout", 32'(reqout), 32'd0);
            if (inject && b == 0) begin
                cmdin = 3'b010; lenin = 2'b11; addrdatain = 32'h0;
            end else begin
                cmdin = 3'b000;
            end
            tick();
        end
        cmdin = 3'b000;
        check("rd_end_cmd",    32'(cmdout), 32'd0);
        check("rd_end_lenout", 32'(lenout), 32'd0);
        if (inject) begin
            for (int k = 0; k < 3; k++) begin
                check("no_2nd_burst_req", 32'(reqout), 32'd0);
                check("no_2nd_burst_cmd", 32'(cmdout), 32'd0);
                tick();
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; selin = 1'b0; cmdin = 3'b000; lenin = 2'b00;
        addrdatain = '0; ackin = 1'b0;
        repeat (3) tick();
        check_bus_idle("reset");
        reset = 1'b0;
        tick();
        check_bus_idle("post_reset");

        // Fill the whole array so every later read has a defined expectation.
        do_write(32'h00, 2'b11, 1'b1, 32'h0, 1'b0);
        do_write(32'h20, 2'b11, 1'b1, 32'h0, 1'b0);

        // Single write then single read (byte 0x48 wraps to word 2 at depth 16).
        do_write(32'h48, 2'b00, 1'b0, 32'h00AA_BBCC, 1'b0);
        do_read(32'h48, 2'b00, 0, 1'b0);

        // Four-beat burst of 1..4 and readback.
        do_write(32'h100, 2'b10, 1'b0, 32'd1, 1'b0);
        do_read(32'h100, 2'b10, 0, 1'b0);

        // Delayed grant.
        do_read(32'h100, 2'b10, 5, 1'b0);

        // Wrap across the top word: words 14,15,0,1.
        do_write(32'h38, 2'b10, 1'b1, 32'h0, 1'b0);
        do_read(32'h38, 2'b10, 1, 1'b0);
        do_read(32'h00, 2'b01, 0, 1'b0);

        // Stalls inside a write burst, stray request during read data.
        do_write(32'h10, 2'b11, 1'b1, 32'h0, 1'b1);
        do_read(32'h10, 2'b11, 2, 1'b1);

        // Reset in the middle of a read burst.
        $display("RESET mid read burst");
        selin = 1'b1; cmdin = 3'b010; lenin = 2'b10; addrdatain = 32'h100;
        tick();
        cmdin = 3'b000; ackin = 1'b1;
        tick();
        ackin = 1'b0;
        check("pre_reset_beat", 32'(cmdout), 32'd3);
        tick();
        reset = 1'b1;
        tick();
        check_bus_idle("mid_reset");
        tick();
        reset = 1'b0;
        check_bus_idle("mid_reset_held");
        do_read(32'h100, 2'b10, 0, 1'b0);

        // Randomized mix of bursts against the array model.
        for (int t = 0; t < 24; t++) begin
            logic [31:0] a;
            logic [1:0]  l;
            a = 32'($urandom_range(0, 255));
            l = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                do_write(a, l, 1'b1, 32'h0, 1'($urandom_range(0, 1)));
            else
                do_read(a, l, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
